// File: rtl/add.sv
// Two-level carry-lookahead adder computing X+Y+Cin, with sign/carry/parity/zero/overflow flags.
// Latency: one clock; Z and every flag are captured together in a single register stage.
// Backpressure: none; operands are sampled on every rising edge, one result per cycle.
module add #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Cin,
  output logic [WIDTH-1:0] Z,
  output logic             sign,
  output logic             carry,
  output logic             parity,
  output logic             zero,
  output logic             overflow
);

  localparam int NG = WIDTH / 4;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] sum;
  logic [NG-1:0]    grp_g;
  logic [NG-1:0]    grp_p;
  logic [NG:0]      gc;

  assign g   = X & Y;
  assign p   = X ^ Y;
  assign sum = p ^ c;

  // First level: each 4-bit group expands its internal carries directly from
  // g/p and the group carry-in, and reports its own generate/propagate.
  for (genvar k = 0; k < NG; k++) begin : g_grp
    localparam int B = 4 * k;

    assign c[B]   = gc[k];
    assign c[B+1] = g[B] | (p[B] & gc[k]);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[k]);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & gc[k]);

    assign grp_g[k] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                    | (p[B+3] & p[B+2] & p[B+1] & g[B]);
    assign grp_p[k] = &p[B+3:B];
  end

  // Second level: every group carry-in is a flat sum-of-products over the
  // lower groups' G/P and Cin, so group carries do not chain through each other.
  always_comb begin
    logic term;
    logic acc;
    gc    = '0;
    term  = 1'b0;
    acc   = 1'b0;
    gc[0] = Cin;
    for (int k = 0; k < NG; k++) begin
      term = Cin;
      for (int m = 0; m <= k; m++) begin
        term = term & grp_p[m];
      end
      acc = term;
      for (int j = 0; j <= k; j++) begin
        term = grp_g[j];
        for (int m = j + 1; m <= k; m++) begin
          term = term & grp_p[m];
        end
        acc = acc | term;
      end
      gc[k+1] = acc;
    end
  end

  // Result register: sum and flags (derived from the unregistered sum) update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Z        <= '0;
      sign     <= 1'b0;
      carry    <= 1'b0;
      parity   <= 1'b0;
      zero     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      Z        <= sum;
      sign     <= sum[WIDTH-1];
      carry    <= gc[NG];
      parity   <= ~^sum;
      zero     <= ~|sum;
      overflow <= (X[WIDTH-1] & Y[WIDTH-1] & ~sum[WIDTH-1])
                | (~X[WIDTH-1] & ~Y[WIDTH-1] & sum[WIDTH-1]);
    end
  end

endmodule

// File: tb/tb_add.sv
// Scoreboard bench for add at WIDTH 4, 8 and 16 running side by side.
// Latency: expected results are compared one cycle after their operands are driven.
// Backpressure: none; operands change every cycle.
module tb_add;

  logic clk;
  logic rst_n;

  logic [3:0]  x4, y4, z4;
  logic [7:0]  x8, y8, z8;
  logic [15:0] x16, y16, z16;
  logic        cin4, cin8, cin16;
  logic        s4, c4, p4, zr4, o4;
  logic        s8, c8, p8, zr8, o8;
  logic        s16, c16, p16, zr16, o16;

  logic [20:0] q4[$];
  logic [20:0] q8[$];
  logic [20:0] q16[$];

  int n_chk;
  int n_err;

  add #(.WIDTH(4)) u_add4 (
    .clk(clk), .rst_n(rst_n), .X(x4), .Y(y4), .Cin(cin4),
    .Z(z4), .sign(s4), .carry(c4), .parity(p4), .zero(zr4), .overflow(o4)
  );

  add #(.WIDTH(8)) u_add8 (
    .clk(clk), .rst_n(rst_n), .X(x8), .Y(y8), .Cin(cin8),
    .Z(z8), .sign(s8), .carry(c8), .parity(p8), .zero(zr8), .overflow(o8)
  );

  add #(.WIDTH(16)) u_add16 (
    .clk(clk), .rst_n(rst_n), .X(x16), .Y(y16), .Cin(cin16),
    .Z(z16), .sign(s16), .carry(c16), .parity(p16), .zero(zr16), .overflow(o16)
  );

  // Free-running clock, 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  // Packed layout: {Z zero-extended to 16 bits, sign, carry, parity, zero, overflow}.
  function automatic logic [20:0] obs4();
    return {12'b0, z4, s4, c4, p4, zr4, o4};
  endfunction
  function automatic logic [20:0] obs8();
    return {8'b0, z8, s8, c8, p8, zr8, o8};
  endfunction
  function automatic logic [20:0] obs16();
    return {z16, s16, c16, p16, zr16, o16};
  endfunction

  // Behavioural reference: plain integer addition, flags from their definitions.
  function automatic logic [20:0] model(input int w, input logic [15:0] a,
                                        input logic [15:0] b, input logic ci);
    logic [16:0] full;
    logic [16:0] mask;
    logic [15:0] z;
    logic        s, co, par, zr, ov;
    mask = (17'd1 << w) - 17'd1;
    full = {1'b0, a} + {1'b0, b} + {16'b0, ci};
    z    = full[15:0] & mask[15:0];
    co   = full[w];
    s    = z[w-1];
    par  = ~^z;
    zr   = (z == 16'd0);
    ov   = (a[w-1] == b[w-1]) && (z[w-1] != a[w-1]);
    return {z, s, co, par, zr, ov};
  endfunction

  task automatic check(input string tag, input logic [20:0] got, input logic [20:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic compare_heads();
    if (q4.size() > 0)  check("w4",  obs4(),  q4.pop_front());
    if (q8.size() > 0)  check("w8",  obs8(),  q8.pop_front());
    if (q16.size() > 0) check("w16", obs16(), q16.pop_front());
  endtask

  // One cycle: compare what the previous operands produced, then drive new ones.
  // When use_lit is set the WIDTH=4 expectation is the hand-derived literal.
  task automatic step(input logic [3:0] a4, input logic [3:0] b4, input logic ci4,
                      input logic use_lit, input logic [8:0] lit4);
    @(negedge clk);
    compare_heads();
    x4   = a4;
    y4   = b4;
    cin4 = ci4;
    x8   = 8'($urandom);
    y8   = 8'($urandom);
    cin8 = 1'($urandom);
    x16  = 16'($urandom);
    y16  = 16'($urandom);
    cin16 = 1'($urandom);
    if (use_lit) q4.push_back({12'b0, lit4});
    else         q4.push_back(model(4, {12'b0, a4}, {12'b0, b4}, ci4));
    q8.push_back(model(8, {8'b0, x8}, {8'b0, y8}, cin8));
    q16.push_back(model(16, x16, y16, cin16));
  endtask

  task automatic drain();
    @(negedge clk);
    compare_heads();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_w4"},  obs4(),  21'd0);
    check({tag, "_w8"},  obs8(),  21'd0);
    check({tag, "_w16"}, obs16(), 21'd0);
  endtask

  // Directed WIDTH=4 vectors: {X, Y, Cin, Z, sign, carry, parity, zero, overflow}.
  logic [17:0] dir_tab [7] = '{
    {4'b0010, 4'b0011, 1'b0, 4'b0101, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0},
    {4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0},
    {4'b1100, 4'b0011, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0},
    {4'b0111, 4'b0101, 1'b0, 4'b1100, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1},
    {4'b1000, 4'b1111, 1'b0, 4'b0111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1},
    {4'b1101, 4'b0110, 1'b1, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
    {4'b1111, 4'b1111, 1'b0, 4'b1110, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}
  };

  initial begin
    logic [17:0] row;
    n_chk = 0;
    n_err = 0;

    // Reset held with nonzero operands while the clock runs: outputs stay 0.
    rst_n = 1'b0;
    x4 = 4'b1111;  y4 = 4'b0001;  cin4 = 1'b0;
    x8 = 8'hff;    y8 = 8'h01;    cin8 = 1'b1;
    x16 = 16'hffff; y16 = 16'h0001; cin16 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("rst_hold");

    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors, back to back.
    for (int i = 0; i < 7; i++) begin
      row = dir_tab[i];
      step(row[17:14], row[13:10], row[9], 1'b1, row[8:0]);
    end

    // Randomized back-to-back operation on all widths.
    for (int i = 0; i < 1000; i++) begin
      step(4'($urandom), 4'($urandom), 1'($urandom), 1'b0, 9'd0);
    end
    drain();

    // Mid-stream reset: a nonzero result is captured, then rst_n drops between
    // edges and must clear everything immediately; the in-flight result is dropped.
    step(4'b0010, 4'b0011, 1'b0, 1'b0, 9'd0);
    drain();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_async");
    q4.delete();
    q8.delete();
    q16.delete();
    @(posedge clk);
    #1;
    check_all_zero("rst_again");

    // First capture after release is on the first rising edge with rst_n high.
    @(negedge clk);
    rst_n = 1'b1;
    q4.push_back(model(4, {12'b0, x4}, {12'b0, y4}, cin4));
    q8.push_back(model(8, {8'b0, x8}, {8'b0, y8}, cin8));
    q16.push_back(model(16, x16, y16, cin16));
    for (int i = 0; i < 20; i++) begin
      step(4'($urandom), 4'($urandom), 1'($urandom), 1'b0, 9'd0);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
